// File: rtl/route_entry_write_arbiter_pkg.sv
// Shared types for the routing-entry write arbiter: FSM state encoding and entry word type.
package route_entry_pkg;

    localparam int unsigned ROUTE_DATA_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY
    } rea_state_t;

    typedef logic [ROUTE_DATA_W-1:0] route_entry_t;

endpackage

// File: rtl/route_entry_write_arbiter_if.sv
// Requester/entry-register bus of the routing-entry write arbiter.
interface route_entry_write_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 24
);
    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      entry_load;
    logic [DATA_W-1:0]         entry_data;
    logic [DATA_W-1:0]         entry_q;
    logic [IW-1:0]             grant_id;
    logic                      busy;
    logic                      verify_err;

    modport master (
        output req_valid, req_data, entry_q,
        input  req_ready, entry_load, entry_data, grant_id, busy, verify_err
    );

    modport slave (
        input  req_valid, req_data, entry_q,
        output req_ready, entry_load, entry_data, grant_id, busy, verify_err
    );

endinterface

// File: rtl/route_entry_write_arbiter_rr_priority_pick.sv
// Round-robin picker: first set request strictly after i_last, wrapping, as one-hot and index.
module rr_priority_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_last,
    output logic [NUM_REQ-1:0] o_gnt_oh,
    output logic [IW-1:0]      o_gnt_idx,
    output logic               o_valid
);
    logic [IW-1:0] w_pos;

    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        o_valid   = 1'b0;
        w_pos     = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_pos = IW'((32'(i_last) + k) % NUM_REQ);
            if (!o_valid && i_req[w_pos]) begin
                o_valid         = 1'b1;
                o_gnt_idx       = w_pos;
                o_gnt_oh[w_pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/route_entry_write_arbiter.sv
// Round-robin sequencer sharing one routing-entry register between NUM_REQ writers.
// Define ROUTE_ENTRY_VERIFY_EN to enable readback compare with bounded reload retries.
module route_entry_write_arbiter
    import route_entry_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = ROUTE_DATA_W,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                       clock,
    input  logic                       clear,
    route_entry_write_arbiter_if.slave bus
);
    localparam int unsigned IW = $clog2(NUM_REQ);

    rea_state_t         r_state;
    rea_state_t         w_next;
    logic [DATA_W-1:0]  r_entry_data;
    logic [IW-1:0]      r_grant_id;
    logic [IW-1:0]      r_last_grant;
    logic [NUM_REQ-1:0] w_gnt_oh;
    logic [IW-1:0]      w_gnt_idx;
    logic               w_any;
    logic               w_done;
    logic [DATA_W-1:0]  w_sel_data;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .i_req     (bus.req_valid),
        .i_last    (r_last_grant),
        .o_gnt_oh  (w_gnt_oh),
        .o_gnt_idx (w_gnt_idx),
        .o_valid   (w_any)
    );

    always_comb begin
        w_sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_sel_data = w_sel_data | bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef ROUTE_ENTRY_VERIFY_EN
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RW-1:0] r_retry_cnt;
    logic          r_verify_err;
    logic          w_mismatch;
    logic          w_can_retry;

    assign w_mismatch  = (bus.entry_q != r_entry_data);
    assign w_can_retry = (r_retry_cnt < RW'(MAX_RETRY));

    always_ff @(posedge clock) begin
        if (clear) begin
            r_retry_cnt  <= '0;
            r_verify_err <= 1'b0;
        end else if (r_state == IDLE && w_any) begin
            r_retry_cnt <= '0;
        end else if (r_state == VERIFY && w_mismatch) begin
            if (w_can_retry) begin
                r_retry_cnt <= r_retry_cnt + RW'(1);
            end else begin
                r_verify_err <= 1'b1;
            end
        end
    end

    assign bus.verify_err = r_verify_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg   = ^{bus.entry_q, MAX_RETRY};
    assign bus.verify_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            IDLE:    if (w_any) w_next = LOAD;
            LOAD:    w_next = VERIFY;
            VERIFY: begin
`ifdef ROUTE_ENTRY_VERIFY_EN
                if (w_mismatch && w_can_retry) begin
                    w_next = LOAD;
                end else begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
`else
                w_done = 1'b1;
                w_next = IDLE;
`endif
            end
            default: w_next = IDLE;
        endcase
    end

    // Pointer starts at NUM_REQ-1 so requester 0 wins the first arbitration after clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state      <= IDLE;
            r_entry_data <= '0;
            r_grant_id   <= '0;
            r_last_grant <= IW'(NUM_REQ - 1);
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_entry_data <= w_sel_data;
                r_grant_id   <= w_gnt_idx;
            end
            if (w_done) begin
                r_last_grant <= r_grant_id;
            end
        end
    end

    assign bus.req_ready  = w_done ? (NUM_REQ'(1) << r_grant_id) : '0;
    assign bus.entry_load = (r_state == LOAD);
    assign bus.entry_data = r_entry_data;
    assign bus.grant_id   = r_grant_id;
    assign bus.busy       = (r_state != IDLE);

endmodule
